serial_subtractor_nbit: RTL and testbench

- Multi-cycle bit-serial unsigned subtractor. Computes a - b - borrow_in one bit per clock, LSB first.
- Runs under a start/busy/done handshake.
- It is the arithmetic inverse of the datapath ripple-carry adder. Sits beside it in the datapath where area matters more than latency.
- Default width 8; result held until the next operation.

---
 rtl/serial_subtractor_nbit_pkg.sv | 17 +
 rtl/serial_subtractor_nbit_if.sv | 25 ++
 rtl/serial_subtractor_nbit_full_subtractor_1bit.sv | 13 +
 rtl/serial_subtractor_nbit.sv | 117 +++++++++++
 tb/tb_serial_subtractor_nbit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_nbit_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_nbit_pkg;

  localparam int unsigned DEFAULT_BIT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One spare bit so the counter never wraps before the terminal compare.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_nbit_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface serial_subtractor_nbit_if
  import serial_subtractor_nbit_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH
);
  logic                 start;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 borrow_in;
  logic [BIT_WIDTH-1:0] difference;
  logic                 underflow;
  logic                 busy;
  logic                 done;

  modport master (
    output start, a, b, borrow_in,
    input  difference, underflow, busy, done
  );

  modport slave (
    input  start, a, b, borrow_in,
    output difference, underflow, busy, done
  );
endinterface

// File: rtl/serial_subtractor_nbit_full_subtractor_1bit.sv
// Single-bit full subtractor: diff = a - b - borrow_in.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock under start/busy/done.
module serial_subtractor_nbit
  import serial_subtractor_nbit_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
  input logic                     clk,
  input logic                     n_rst,
  serial_subtractor_nbit_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(BIT_WIDTH);
  localparam int unsigned RES_W = BIT_WIDTH - 1;

  state_e               state, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load_c, shift_c, last_c;

  logic [BIT_WIDTH-1:0] a_sr, b_sr;
  logic [RES_W-1:0]     res_sr;
  logic                 br_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_WIDTH-1:0] difference_q;
  logic                 underflow_q;

  logic                 d_c, br_next_c;

  full_subtractor_1bit u_fs (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .borrow_in  (br_q),
    .diff       (d_c),
    .borrow_out (br_next_c)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.difference = difference_q;
  assign bus.underflow  = underflow_q;

  // State and handshake flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Next state and datapath controls
  always_comb begin
    state_d = state;
    load_c  = 1'b0;
    shift_c = 1'b0;
    last_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (cnt_q == CNT_W'(BIT_WIDTH - 1)) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // Operand/result shift registers; outputs load only on the final bit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sr         <= '0;
      b_sr         <= '0;
      res_sr       <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      difference_q <= '0;
      underflow_q  <= 1'b0;
    end else if (load_c) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      br_q  <= bus.borrow_in;
      cnt_q <= '0;
    end else if (shift_c) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      br_q   <= br_next_c;
      res_sr <= RES_W'({d_c, res_sr} >> 1);
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last_c) begin
        difference_q <= {d_c, res_sr};
        underflow_q  <= br_next_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Randomized self-checking bench for serial_subtractor_nbit against an arithmetic model.
module tb_serial_subtractor_nbit;

  localparam int unsigned W      = 8;
  localparam int          BUDGET = 4 * W;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  serial_subtractor_nbit_if #(.BIT_WIDTH(W)) bus ();

  serial_subtractor_nbit #(.BIT_WIDTH(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_diff = '0;
  logic         exp_uf   = 1'b0;

  // Reference: plain signed arithmetic, result taken modulo 2^W
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bin);
    longint r;
    r = longint'(a) - longint'(b) - longint'(bin);
    return {(r < 0) ? 1'b1 : 1'b0, W'(r)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.borrow_in = 1'b0;
    step();
    step();
    checks++;
    if (bus.difference !== '0) begin
      errors++; $display("FAIL reset_difference: got %0h expected 0", bus.difference);
    end
    checks++;
    if (bus.underflow !== 1'b0) begin
      errors++; $display("FAIL reset_underflow: got %0b expected 0", bus.underflow);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %0b expected 0", bus.done);
    end
    n_rst = 1'b1;
    step();
    exp_diff = '0;
    exp_uf = 1'b0;
  endtask

  // Waits for done, checking that outputs hold the previous result meanwhile
  task automatic wait_done(input int start_cyc, input string tag, output int cyc);
    cyc = start_cyc;
    while (bus.done !== 1'b1 && cyc < BUDGET) begin
      checks++;
      if ({bus.underflow, bus.difference} !== {exp_uf, exp_diff}) begin
        errors++;
        $display("FAIL %s_hold: got uf=%0b diff=%0h expected uf=%0b diff=%0h",
                 tag, bus.underflow, bus.difference, exp_uf, exp_diff);
      end
      step();
      cyc++;
    end
  endtask

  task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                              input int cyc, input string tag);
    logic [W:0] m;
    m = model(a, b, bin);
    checks++;
    if (cyc != W) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", tag, cyc, W);
    end
    checks++;
    if (bus.difference !== m[W-1:0]) begin
      errors++;
      $display("FAIL %s_difference: a=%0h b=%0h bin=%0b got %0h expected %0h",
               tag, a, b, bin, bus.difference, m[W-1:0]);
    end
    checks++;
    if (bus.underflow !== m[W]) begin
      errors++;
      $display("FAIL %s_underflow: a=%0h b=%0h bin=%0b got %0b expected %0b",
               tag, a, b, bin, bus.underflow, m[W]);
    end
    exp_diff = m[W-1:0];
    exp_uf = m[W];
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input string tag);
    int cyc;
    bus.a = a;
    bus.b = b;
    bus.borrow_in = bin;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.borrow_in = 1'($urandom_range(0, 1));
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy: got %0b expected 1", tag, bus.busy);
    end
    wait_done(0, tag, cyc);
    check_result(a, b, bin, cyc, tag);
    step();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL %s_idle: got busy/done=%b expected 00", tag, {bus.busy, bus.done});
    end
  endtask

  task automatic test_directed();
    run_op(8'd100, 8'd37, 1'b0, "basic");
    run_op(8'd5, 8'd10, 1'b0, "underflow");
    run_op(8'h00, 8'h00, 1'b1, "borrow_zero");
    run_op(8'hFF, 8'hFF, 1'b0, "borrow_ff");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_ignored_start();
    int cyc;
    bus.a = 8'd200;
    bus.b = 8'd50;
    bus.borrow_in = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.start = 1'b1;
    bus.a = 8'd1;
    bus.b = 8'd1;
    step();
    bus.start = 1'b0;
    wait_done(3, "ignored", cyc);
    check_result(8'd200, 8'd50, 1'b0, cyc, "ignored");
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL ignored_no_restart: got busy=%0b expected 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [W-1:0] oa, ob;
    logic         obin;
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      oa = W'($urandom);
      ob = W'($urandom);
      obin = 1'($urandom_range(0, 1));
      bus.a = oa;
      bus.b = ob;
      bus.borrow_in = obin;
      step();
      checks++;
      if ({bus.busy, bus.done} !== 2'b10) begin
        errors++;
        $display("FAIL b2b_accept: op=%0d got busy/done=%b expected 10", i, {bus.busy, bus.done});
      end
      wait_done(0, "b2b", cyc);
      check_result(oa, ob, obin, cyc, "b2b");
    end
    bus.start = 1'b0;
    step();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL b2b_end: got busy/done=%b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_reset_mid();
    bus.a = 8'd77;
    bus.b = 8'd12;
    bus.borrow_in = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    n_rst = 1'b0;
    #1;
    checks++;
    if ({bus.underflow, bus.difference, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got uf=%0b diff=%0h busy=%0b done=%0b expected all 0",
               bus.underflow, bus.difference, bus.busy, bus.done);
    end
    exp_diff = '0;
    exp_uf = 1'b0;
    for (int i = 0; i < W; i++) begin
      step();
      checks++;
      if (bus.done !== 1'b0) begin
        errors++; $display("FAIL midreset_no_done: got %0b expected 0", bus.done);
      end
    end
    n_rst = 1'b1;
    step();
    run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
